// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with prescaler, parallel load, wrap/saturate
// limit handling and registered terminal-count / limit status.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned MODULUS  = 4096,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PS_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_evt
);

  // One extra bit so MODULUS = 2^WIDTH compares without aliasing to zero.
  localparam int unsigned     CW      = WIDTH + 1;
  localparam logic [CW-1:0]   MOD_EXT = CW'(MODULUS);
  localparam logic [CW-1:0]   MAX_EXT = CW'(MODULUS - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_d;
  logic [CW-1:0]    count_ext, load_ext;
  logic             tc_d, at_max_d, at_min_d, evt_d;

  // Next-state: load beats step beats hold.
  always_comb begin
    count_ext = {1'b0, count};
    load_ext  = {1'b0, load_val};
    count_d   = count;
    ps_d      = ps_q;
    tc_d      = 1'b0;
    evt_d     = limit_evt & ~clr_flag;

    if (load) begin
      count_d = (load_ext < MOD_EXT) ? load_val : WIDTH'(MAX_EXT);
      ps_d    = '0;
    end else if (en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (up) begin
          if (count_ext < MAX_EXT) begin
            count_d = WIDTH'(count_ext + CW'(1));
          end else begin
            evt_d = 1'b1;
            if (!sat_mode) begin
              count_d = '0;
              tc_d    = 1'b1;
            end
          end
        end else begin
          if (count_ext != '0) begin
            count_d = WIDTH'(count_ext - CW'(1));
          end else begin
            evt_d = 1'b1;
            if (!sat_mode) begin
              count_d = WIDTH'(MAX_EXT);
              tc_d    = 1'b1;
            end
          end
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    // Flags derived from the next count so they line up with count itself.
    at_max_d = ({1'b0, count_d} == MAX_EXT);
    at_min_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      ps_q      <= '0;
      tc        <= 1'b0;
      at_max    <= 1'b0;
      at_min    <= 1'b1;
      limit_evt <= 1'b0;
    end else begin
      count     <= count_d;
      ps_q      <= ps_d;
      tc        <= tc_d;
      at_max    <= at_max_d;
      at_min    <= at_min_d;
      limit_evt <= evt_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: default, mod-10/prescale-3 and 4-bit mod-16 instances.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, sat_mode, load, clr_flag;
  logic [11:0] lv12;
  logic [3:0]  lv4;

  logic [11:0] c12;
  logic        tc12, mx12, mn12, ev12;
  logic [3:0]  c10, c16;
  logic        tc10, mx10, mn10, ev10;
  logic        tc16, mx16, mn16, ev16;

  // Status vectors: {count, tc, at_max, at_min, limit_evt}
  logic [15:0] s12;
  logic [7:0]  s10, s16;
  assign s12 = {c12, tc12, mx12, mn12, ev12};
  assign s10 = {c10, tc10, mx10, mn10, ev10};
  assign s16 = {c16, tc16, mx16, mn16, ev16};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_mod_counter u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
    .load_val(lv12), .clr_flag(clr_flag), .count(c12), .tc(tc12), .at_max(mx12),
    .at_min(mn12), .limit_evt(ev12)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .PS_W(2)) u_m10 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
    .load_val(lv4), .clr_flag(clr_flag), .count(c10), .tc(tc10), .at_max(mx10),
    .at_min(mn10), .limit_evt(ev10)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .PS_W(1)) u_m16 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
    .load_val(lv4), .clr_flag(clr_flag), .count(c16), .tc(tc16), .at_max(mx16),
    .at_min(mn16), .limit_evt(ev16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0; clr_flag = 1'b0;
    lv12 = '0; lv4 = '0;
    for (int i = 0; i < 5; i++) tick();
    tests++; if (s12 !== {12'd0, 4'b0010}) begin fails++; $display("FAIL reset_def: got %h expected %h", s12, {12'd0, 4'b0010}); end
    tests++; if (s10 !== 8'b0000_0010) begin fails++; $display("FAIL reset_m10: got %h expected %h", s10, 8'b0000_0010); end
    tests++; if (s16 !== 8'b0000_0010) begin fails++; $display("FAIL reset_m16: got %h expected %h", s16, 8'b0000_0010); end
  endtask

  task automatic test_up_wrap_default();
    logic [15:0] e;
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 4095; i++) begin
      tick();
      e = {12'(i), 1'b0, 1'(i == 4095), 2'b00};
      tests++; if (s12 !== e) begin fails++; $display("FAIL up_count_%0d: got %h expected %h", i, s12, e); end
    end
    tick();
    tests++; if (s12 !== {12'd0, 4'b1011}) begin fails++; $display("FAIL up_wrap: got %h expected %h", s12, {12'd0, 4'b1011}); end
    tick();
    tests++; if (s12 !== {12'd1, 4'b0001}) begin fails++; $display("FAIL up_after_wrap: got %h expected %h", s12, {12'd1, 4'b0001}); end
  endtask

  task automatic test_saturate_default();
    sat_mode = 1'b1; load = 1'b1; clr_flag = 1'b1; lv12 = 12'd4094;
    tick();
    tests++; if (s12 !== {12'd4094, 4'b0000}) begin fails++; $display("FAIL sat_load: got %h expected %h", s12, {12'd4094, 4'b0000}); end
    load = 1'b0; clr_flag = 1'b0;
    tick();
    tests++; if (s12 !== {12'd4095, 4'b0100}) begin fails++; $display("FAIL sat_reach_max: got %h expected %h", s12, {12'd4095, 4'b0100}); end
    tick();
    tests++; if (s12 !== {12'd4095, 4'b0101}) begin fails++; $display("FAIL sat_block1: got %h expected %h", s12, {12'd4095, 4'b0101}); end
    tick();
    tests++; if (s12 !== {12'd4095, 4'b0101}) begin fails++; $display("FAIL sat_block2: got %h expected %h", s12, {12'd4095, 4'b0101}); end
    clr_flag = 1'b1;
    tick();
    tests++; if (s12 !== {12'd4095, 4'b0101}) begin fails++; $display("FAIL sat_set_beats_clr: got %h expected %h", s12, {12'd4095, 4'b0101}); end
    up = 1'b0;
    tick();
    tests++; if (s12 !== {12'd4094, 4'b0000}) begin fails++; $display("FAIL sat_down_clr: got %h expected %h", s12, {12'd4094, 4'b0000}); end
    clr_flag = 1'b0; sat_mode = 1'b0;
  endtask

  task automatic test_prescale_down();
    logic [7:0] exp_s [9];
    exp_s = '{8'h10, 8'h10, 8'h02, 8'h02, 8'h02, 8'h9D, 8'h95, 8'h95, 8'h81};
    up = 1'b0; sat_mode = 1'b0; en = 1'b1; load = 1'b1; clr_flag = 1'b1; lv4 = 4'd1;
    tick();
    tests++; if (s10 !== 8'h10) begin fails++; $display("FAIL ps_load1: got %h expected %h", s10, 8'h10); end
    load = 1'b0; clr_flag = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      tests++; if (s10 !== exp_s[i]) begin fails++; $display("FAIL ps_step_%0d: got %h expected %h", i, s10, exp_s[i]); end
    end
    tick();
    tests++; if (s10 !== 8'h81) begin fails++; $display("FAIL ps_phase1: got %h expected %h", s10, 8'h81); end
    en = 1'b0;
    tick(); tick();
    tests++; if (s10 !== 8'h81) begin fails++; $display("FAIL ps_en_hold: got %h expected %h", s10, 8'h81); end
    en = 1'b1;
    tick();
    tests++; if (s10 !== 8'h81) begin fails++; $display("FAIL ps_phase2: got %h expected %h", s10, 8'h81); end
    tick();
    tests++; if (s10 !== 8'h71) begin fails++; $display("FAIL ps_resume_step: got %h expected %h", s10, 8'h71); end
  endtask

  task automatic test_load();
    load = 1'b1; lv4 = 4'd15; en = 1'b1; up = 1'b0;
    tick();
    tests++; if (s10 !== 8'h95) begin fails++; $display("FAIL load_clamp: got %h expected %h", s10, 8'h95); end
    load = 1'b0;
    tick(); tick();
    tests++; if (s10 !== 8'h95) begin fails++; $display("FAIL load_pre_tick: got %h expected %h", s10, 8'h95); end
    load = 1'b1; lv4 = 4'd3;
    tick();
    tests++; if (s10 !== 8'h31) begin fails++; $display("FAIL load_beats_step: got %h expected %h", s10, 8'h31); end
    load = 1'b0;
    tick(); tick();
    tests++; if (s10 !== 8'h31) begin fails++; $display("FAIL load_ps_cleared: got %h expected %h", s10, 8'h31); end
    tick();
    tests++; if (s10 !== 8'h21) begin fails++; $display("FAIL load_then_step: got %h expected %h", s10, 8'h21); end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; lv4 = 4'd7;
    tick();
    load = 1'b0; up = 1'b1;
    tick();
    tests++; if (s10 !== 8'h71) begin fails++; $display("FAIL rst_mid_pre: got %h expected %h", s10, 8'h71); end
    rst_n = 1'b0;
    tick();
    tests++; if (s10 !== 8'h02) begin fails++; $display("FAIL rst_mid: got %h expected %h", s10, 8'h02); end
    load = 1'b1; lv4 = 4'd5;
    tick();
    tests++; if (s10 !== 8'h02) begin fails++; $display("FAIL rst_beats_load: got %h expected %h", s10, 8'h02); end
    rst_n = 1'b1; load = 1'b0;
    tick(); tick();
    tests++; if (s10 !== 8'h02) begin fails++; $display("FAIL rst_ps_zero: got %h expected %h", s10, 8'h02); end
    tick();
    tests++; if (s10 !== 8'h10) begin fails++; $display("FAIL rst_first_step: got %h expected %h", s10, 8'h10); end
  endtask

  task automatic test_full_width_wrap();
    sat_mode = 1'b0; up = 1'b1; en = 1'b1; load = 1'b1; lv4 = 4'd14;
    tick();
    tests++; if (s16 !== 8'hE0) begin fails++; $display("FAIL w4_load: got %h expected %h", s16, 8'hE0); end
    load = 1'b0;
    tick();
    tests++; if (s16 !== 8'hF4) begin fails++; $display("FAIL w4_max: got %h expected %h", s16, 8'hF4); end
    tick();
    tests++; if (s16 !== 8'h0B) begin fails++; $display("FAIL w4_wrap: got %h expected %h", s16, 8'h0B); end
    tick();
    tests++; if (s16 !== 8'h11) begin fails++; $display("FAIL w4_after_wrap: got %h expected %h", s16, 8'h11); end
    sat_mode = 1'b1; load = 1'b1;
    tick();
    tests++; if (s16 !== 8'hE1) begin fails++; $display("FAIL w4_sat_load: got %h expected %h", s16, 8'hE1); end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (s16 !== 8'hF5) begin fails++; $display("FAIL w4_sat_hold_%0d: got %h expected %h", i, s16, 8'hF5); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap_default();
    test_saturate_default();
    test_prescale_down();
    test_load();
    test_reset_mid();
    test_full_width_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the free-running 12-bit up counter.
- Adds configurable width and modulus, up/down direction, count enable, prescaled stepping, parallel load, and wrap or saturate limit handling.
- Adds registered status outputs for terminal count, limit detection and a sticky limit-event flag.
- Sits beside the existing counter as the general-purpose counting/timing block for lab datapaths and display drivers.

Parameters:
- WIDTH, 12, bit width of count and load_val.
- MODULUS, 4096, number of count states: count ranges 0..MODULUS-1. Legal range is 2..2^WIDTH.
- PRESCALE, 1, number of enabled clock cycles per count step. Must be ≥1; 1 means a step on every enabled cycle.
- PS_W, 16, prescaler counter width. Must satisfy 2^PS_W ≥ PRESCALE.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; gates both the prescaler and stepping.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat_mode  in  1  limit behaviour: 0 = wrap, 1 = saturate.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- clr_flag  in  1  clears limit_evt.
- count  out  WIDTH  current count, registered.
- tc  out  1  one-cycle terminal-count pulse on wrap, registered.
- at_max  out  1  registered; high iff count == MODULUS-1.
- at_min  out  1  registered; high iff count == 0.
- limit_evt  out  1  sticky flag; set on any wrap or saturation-blocked step.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low. Sampled only on rising clk.
  - rst_n=0 at an edge gives count=0, prescaler=0, tc=0, at_max=0, at_min=1, limit_evt=0.
  - Reset mid-operation is legal at any cycle and takes effect at that edge.
- Priority per edge: reset > load > step > hold.
- Load:
  - count <= load_val if load_val < MODULUS, else MODULUS-1 (clamped).
  - Prescaler cleared. tc=0 that cycle. limit_evt unaffected, unless clr_flag is also asserted.
- Prescaler:
  - When en=1 and load=0: if ps == PRESCALE-1 then ps <= 0 and a step tick occurs; else ps <= ps+1.
  - en=0 holds ps (no clear) and holds count.
- Step, on tick:
  - up=1, count < MODULUS-1: count+1.
  - up=1, count == MODULUS-1:
    - wrap mode: count <= 0, tc=1, limit_evt <= 1.
    - saturate mode: count held, tc=0, limit_evt <= 1.
  - up=0, count > 0: count-1.
  - up=0, count == 0:
    - wrap mode: count <= MODULUS-1, tc=1, limit_evt <= 1.
    - saturate mode: count held, tc=0, limit_evt <= 1.
- Arithmetic: evaluated at WIDTH+1 bits internally, so no unintended 2^WIDTH wrap when MODULUS = 2^WIDTH.
- tc:
  - High for exactly the one cycle following the wrapping edge, then 0 unless another wrap occurs.
  - With PRESCALE=1 and continuous wrapping at MODULUS=2, tc may stay high on consecutive cycles.
- at_max and at_min: registered from the next-count value, so they are coincident with count (zero lag).
- limit_evt:
  - clr_flag=1 clears it.
  - If a limit event and clr_flag occur in the same cycle, set wins.
- Direction or sat_mode changes take effect on the next tick. Prescaler phase is not disturbed.
- Latency: count changes on the edge at which the tick occurs; a load is visible one cycle after load is sampled.

Test Plan:
1. Defaults (12-bit, MODULUS=4096, PRESCALE=1): rst_n=0 for 5 cycles, then en=1, up=1 → count 0,1,2,… one per cycle. After 4095 steps count=4095 and at_max=1; next edge count=0, tc=1 for one cycle, limit_evt=1.
2. Defaults, sat_mode=1, load 4094, up=1, en=1 → count 4094, 4095, 4095, 4095; tc stays 0; limit_evt=1 from the first blocked step. clr_flag pulse while still blocked → limit_evt stays 1. Then up=0, clr_flag=1 → count=4094, limit_evt=0.
3. MODULUS=10, PRESCALE=3, up=0, en=1 from count=1 → count changes every 3rd cycle: 1, 0, 9 (tc=1), 8. en=0 for 2 cycles mid-period → prescaler phase held, next step lands exactly 3 enabled cycles after the previous one.
4. MODULUS=10: load_val=15 → count=9, at_max=1. load and en together at a tick → load wins; count=load_val, prescaler=0.
5. Reset mid-count (count=7, ps=1, limit_evt=1): rst_n=0 for one edge → count=0, at_min=1, tc=0, limit_evt=0. rst_n=0 held while load=1 → stays 0.
6. WIDTH=4, MODULUS=16, up=1 wrap: 15 → 0 with tc=1 and no spurious intermediate value; sat_mode=1 holds at 15.
